hazard_scoreboard: RTL and testbench

- Parametrised pipeline hazard scoreboard and stall controller; successor to the fixed 16-register, 4-stage nop-insertion control logic.
- Sits beside the decoder. Tracks the destination-register masks of instructions in flight through DEPTH downstream stages.
- Stalls the decode stage on RAW hazards, with optional forwarding, and inserts bubbles downstream.
- Also exposes a busy mask, a stall performance counter and a deadlock watchdog.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_scoreboard_if.sv | 22 ++
 rtl/sb_window_or.sv | 24 ++
 rtl/hazard_scoreboard.sv | 112 +++++++++++
 tb/tb_hazard_scoreboard.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, defaults and mask helper for the hazard scoreboard
package hazard_pkg;

  localparam int NREGS_DEF = 16;
  localparam int DEPTH_DEF = 3;

  // Entry record at the default register count.
  typedef struct packed {
    logic                 valid;
    logic [NREGS_DEF-1:0] prov;
  } sb_entry_t;

  // Bit 0 of a register mask survives only when there is no hardwired zero register.
  function automatic logic mask_zero(input logic bit0, input bit zero_reg);
    return bit0 & ~zero_reg;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-side handshake between decoder and scoreboard
interface hazard_scoreboard_if #(
  parameter int NREGS = 16
);

  logic             id_valid;
  logic [NREGS-1:0] id_req;
  logic [NREGS-1:0] id_prov;
  logic             id_stall;
  logic             id_issue;

  modport master (
    output id_valid, id_req, id_prov,
    input  id_stall, id_issue
  );

  modport slave (
    input  id_valid, id_req, id_prov,
    output id_stall, id_issue
  );

endinterface

// File: rtl/sb_window_or.sv
// rtl/sb_window_or.sv - OR of destination masks over valid entries in [LO, HI)
module sb_window_or
  import hazard_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LO    = 0,
  parameter int HI    = DEPTH
) (
  input  logic [DEPTH-1:0]            valid,
  input  logic [DEPTH-1:0][NREGS-1:0] prov,
  output logic [NREGS-1:0]            mask
);

  always_comb begin
    mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k >= LO && k < HI && valid[k]) begin
        mask = mask | prov[k];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW hazard scoreboard, decode stall control and stall watchdog
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS     = NREGS_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int FWD_EN    = 0,
  parameter int FWD_STAGE = 1,
  parameter int ZERO_REG  = 1,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_scoreboard_if.slave   id,
  input  logic                 advance,
  input  logic                 flush,
  output logic [DEPTH-1:0]     stage_valid,
  output logic [NREGS-1:0]     busy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic                 watchdog
);

  // Entries at or beyond the window deliver their result through forwarding.
  localparam int WIN   = (FWD_EN != 0) ? FWD_STAGE : DEPTH;
  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  logic [DEPTH-1:0]            ent_valid;
  logic [DEPTH-1:0][NREGS-1:0] ent_prov;
  logic [NREGS-1:0]            req_m;
  logic [NREGS-1:0]            prov_m;
  logic [NREGS-1:0]            p_win;
  logic                        hazard;
  logic                        issue;
  logic [RUN_W-1:0]            run_cnt;
  logic [RUN_W-1:0]            run_next;

  assign req_m  = {id.id_req[NREGS-1:1],  mask_zero(id.id_req[0],  ZERO_REG != 0)};
  assign prov_m = {id.id_prov[NREGS-1:1], mask_zero(id.id_prov[0], ZERO_REG != 0)};

  sb_window_or #(
    .NREGS (NREGS),
    .DEPTH (DEPTH),
    .LO    (0),
    .HI    (WIN)
  ) u_hazard_or (
    .valid (ent_valid),
    .prov  (ent_prov),
    .mask  (p_win)
  );

  sb_window_or #(
    .NREGS (NREGS),
    .DEPTH (DEPTH),
    .LO    (0),
    .HI    (DEPTH)
  ) u_busy_or (
    .valid (ent_valid),
    .prov  (ent_prov),
    .mask  (busy)
  );

  assign hazard      = id.id_valid & (|(req_m & p_win));
  assign issue       = id.id_valid & ~hazard & advance;
  assign id.id_stall = id.id_valid & (hazard | ~advance);
  assign id.id_issue = issue;
  assign stage_valid = ent_valid;

  // Entry DEPTH-1 falls off the end on every advancing edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_valid <= '0;
      ent_prov  <= '0;
    end else if (flush) begin
      ent_valid <= '0;
      ent_prov  <= '0;
    end else if (advance) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_prov[k]  <= ent_prov[k-1];
      end
      ent_valid[0] <= issue;
      ent_prov[0]  <= issue ? prov_m : '0;
    end
  end

  // Only hazard stalls count; a flush cycle is never a stall cycle for the counters.
  always_comb begin
    run_next = '0;
    if (!flush && hazard) begin
      run_next = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      run_cnt   <= '0;
      watchdog  <= 1'b0;
    end else begin
      run_cnt <= run_next;
      if (!flush && hazard && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (run_next == RUN_MAX) begin
        watchdog <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed bench with a behavioural model for hazard_scoreboard
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NR   = 16;
  localparam int DP   = 3;
  localparam int MAXS = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic advance = 1'b1;
  logic flush = 1'b0;
  logic in_v = 1'b0;
  logic [NR-1:0] in_req = '0;
  logic [NR-1:0] in_prov = '0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREGS(NR)) if0 ();
  hazard_scoreboard_if #(.NREGS(NR)) if1 ();

  assign if0.id_valid = in_v;
  assign if0.id_req   = in_req;
  assign if0.id_prov  = in_prov;
  assign if1.id_valid = in_v;
  assign if1.id_req   = in_req;
  assign if1.id_prov  = in_prov;

  logic [DP-1:0] sv0, sv1;
  logic [NR-1:0] bz0, bz1;
  logic [15:0]   sc0, sc1;
  logic          wd0, wd1;

  hazard_scoreboard u0 (
    .clk(clk), .reset(reset), .id(if0.slave), .advance(advance), .flush(flush),
    .stage_valid(sv0), .busy(bz0), .stall_cnt(sc0), .watchdog(wd0)
  );

  hazard_scoreboard #(.FWD_EN(1), .FWD_STAGE(1)) u1 (
    .clk(clk), .reset(reset), .id(if1.slave), .advance(advance), .flush(flush),
    .stage_valid(sv1), .busy(bz1), .stall_cnt(sc1), .watchdog(wd1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", name, d, act, exp, $time);
    end
  endtask

  // Model: each in-flight instruction is a slot record; forwarding only narrows
  // which slots a source register may collide with.
  sb_entry_t m[2][DP];
  int mcnt[2];
  int mrun[2];
  bit mwd[2];
  int win[2] = '{DP, 1};
  logic mhz;

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < DP; k++) begin
        m[d][k].valid = 1'b0;
        m[d][k].prov  = '0;
      end
      mcnt[d] = 0;
      mrun[d] = 0;
      mwd[d]  = 1'b0;
    end
  endtask

  function automatic logic m_hz(input int d);
    logic [NR-1:0] p;
    p = '0;
    for (int k = 0; k < win[d]; k++) if (m[d][k].valid) p |= m[d][k].prov;
    return in_v && ((in_req & 16'hFFFE & p) != 0);
  endfunction

  function automatic logic [NR-1:0] m_busy(input int d);
    logic [NR-1:0] p;
    p = '0;
    for (int k = 0; k < DP; k++) if (m[d][k].valid) p |= m[d][k].prov;
    return p;
  endfunction

  function automatic logic [DP-1:0] m_sv(input int d);
    logic [DP-1:0] v;
    for (int k = 0; k < DP; k++) v[k] = m[d][k].valid;
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_clear();
    end else begin
      for (int d = 0; d < 2; d++) begin
        mhz = m_hz(d);
        if (flush) begin
          for (int k = 0; k < DP; k++) begin
            m[d][k].valid = 1'b0;
            m[d][k].prov  = '0;
          end
          mrun[d] = 0;
        end else begin
          if (mhz) begin
            if (mcnt[d] < 65535) mcnt[d]++;
            if (mrun[d] < MAXS) mrun[d]++;
            if (mrun[d] == MAXS) mwd[d] = 1'b1;
          end else begin
            mrun[d] = 0;
          end
          if (advance) begin
            for (int k = DP - 1; k > 0; k--) m[d][k] = m[d][k-1];
            m[d][0].valid = in_v && !mhz;
            m[d][0].prov  = (in_v && !mhz) ? (in_prov & 16'hFFFE) : '0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic hz;
      hz = m_hz(d);
      chk("id_stall",    d, (d == 0) ? 32'(if0.id_stall) : 32'(if1.id_stall), 32'(in_v & (hz | ~advance)));
      chk("id_issue",    d, (d == 0) ? 32'(if0.id_issue) : 32'(if1.id_issue), 32'(in_v & ~hz & advance));
      chk("stage_valid", d, (d == 0) ? 32'(sv0) : 32'(sv1), 32'(m_sv(d)));
      chk("busy",        d, (d == 0) ? 32'(bz0) : 32'(bz1), 32'(m_busy(d)));
      chk("stall_cnt",   d, (d == 0) ? 32'(sc0) : 32'(sc1), 32'(mcnt[d]));
      chk("watchdog",    d, (d == 0) ? 32'(wd0) : 32'(wd1), 32'(mwd[d]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int  n0, n1;
  bit  done0, done1;

  initial begin
    model_clear();
    #1 reset = 1'b0;
    #1;
    chk("rst_sv", 0, 32'(sv0), 0);
    chk("rst_busy", 0, 32'(bz0), 0);
    chk("rst_cnt", 0, 32'(sc0), 0);
    chk("rst_wd", 0, 32'(wd0), 0);
    chk("rst_stall_idle", 0, 32'(if0.id_stall), 0);
    in_v = 1'b1; advance = 1'b0;
    #1;
    chk("rst_stall_hold", 0, 32'(if0.id_stall), 1);
    chk("rst_issue_hold", 0, 32'(if0.id_issue), 0);
    in_v = 1'b0; advance = 1'b1;
    step(); step();
    reset = 1'b1;
    step();

    // Back-to-back RAW on r2
    in_v = 1'b1; in_prov = 16'h0004; in_req = '0;
    step();
    in_prov = '0; in_req = 16'h0004;
    n0 = 0; n1 = 0; done0 = 0; done1 = 0;
    for (int i = 0; i < 10 && !(done0 && done1); i++) begin
      #1;
      if (!done0) begin if (if0.id_issue) done0 = 1; else n0++; end
      if (!done1) begin if (if1.id_issue) done1 = 1; else n1++; end
      if (i == 0) begin
        chk("raw_busy", 0, 32'(bz0), 32'h4);
        chk("raw_busy", 1, 32'(bz1), 32'h4);
      end
      step();
    end
    chk("raw_stalls", 0, n0, 3);
    chk("raw_stalls", 1, n1, 1);
    in_v = 1'b0; in_req = '0;
    repeat (4) step();
    chk("raw_cnt", 0, 32'(sc0), 3);
    chk("raw_cnt", 1, 32'(sc1), 1);

    // Zero register never creates a dependency
    in_v = 1'b1; in_prov = 16'h0001;
    step();
    in_prov = '0; in_req = 16'h0001;
    #1;
    chk("zr_stall", 0, 32'(if0.id_stall), 0);
    chk("zr_stall", 1, 32'(if1.id_stall), 0);
    chk("zr_busy", 0, 32'(bz0), 0);
    step();
    in_v = 1'b0; in_req = '0;
    repeat (3) step();

    // Hold then flush
    in_v = 1'b1; in_prov = 16'h0002;
    step();
    in_prov = 16'h0008;
    step();
    in_v = 1'b0; in_prov = '0; advance = 1'b0;
    #1;
    chk("hold_sv_pre", 0, 32'(sv0), 3);
    repeat (4) step();
    chk("hold_sv", 0, 32'(sv0), 3);
    chk("hold_sv", 1, 32'(sv1), 3);
    chk("hold_cnt", 0, 32'(sc0), 3);
    flush = 1'b1;
    step();
    flush = 1'b0; advance = 1'b1;
    chk("flush_sv", 0, 32'(sv0), 0);
    chk("flush_busy", 0, 32'(bz0), 0);
    chk("flush_sv", 1, 32'(sv1), 0);

    // Watchdog on a held producer
    in_v = 1'b1; in_prov = 16'h0010;
    step();
    in_prov = '0; in_req = 16'h0010; advance = 1'b0;
    repeat (14) step();
    chk("wd_early", 0, 32'(wd0), 0);
    chk("wd_early", 1, 32'(wd1), 0);
    step();
    chk("wd_set", 0, 32'(wd0), 1);
    chk("wd_set", 1, 32'(wd1), 1);
    chk("wd_cnt", 0, 32'(sc0), 18);
    chk("wd_cnt", 1, 32'(sc1), 16);
    in_v = 1'b0; in_req = '0; advance = 1'b1;
    step();
    chk("wd_sticky", 0, 32'(wd0), 1);

    // Flush coinciding with a hazard is not a stall cycle
    in_v = 1'b1; in_prov = 16'h0004;
    step();
    in_prov = '0; in_req = 16'h0004; flush = 1'b1;
    step();
    flush = 1'b0; in_v = 1'b0; in_req = '0;
    chk("flush_hz_cnt", 0, 32'(sc0), 18);
    chk("flush_hz_cnt", 1, 32'(sc1), 16);
    chk("flush_hz_sv", 0, 32'(sv0), 0);

    // Asynchronous reset with three entries in flight
    in_v = 1'b1; in_prov = 16'h0020;
    step();
    in_prov = 16'h0040;
    step();
    in_prov = 16'h0080;
    step();
    chk("full_sv", 0, 32'(sv0), 7);
    chk("full_busy", 0, 32'(bz0), 32'h00E0);
    #2 reset = 1'b0;
    #1;
    chk("arst_sv", 0, 32'(sv0), 0);
    chk("arst_busy", 0, 32'(bz0), 0);
    chk("arst_cnt", 0, 32'(sc0), 0);
    chk("arst_wd", 0, 32'(wd0), 0);
    chk("arst_wd", 1, 32'(wd1), 0);
    chk("arst_issue", 0, 32'(if0.id_issue), 1);
    step();
    reset = 1'b1;
    step();
    in_v = 1'b0; in_prov = '0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
